// File: rtl/instr_fetch.sv
// Instruction fetch initiator: owns the PC and drives the registered
// instruction memory port. It pairs each returned word with its address and
// presents the pair to decode over valid/ready. A redirect squashes the word
// currently presented. A misaligned redirect target parks the block in a
// sticky fault state that only reset can clear.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   BOOT  | first cycle after reset; memory is capturing resetVector
//   RUN   | streaming; pc_q is the address whose word is on imem_instr now
//   FAULT | misaligned redirect seen; pc_q holds the faulting target
module instr_fetch #(
   parameter int                  addrWidth   = 32,
   parameter int                  instrWidth  = 32,
   parameter logic [addrWidth-1:0] resetVector = 32'h8000_0000
) (
   input  logic                  clock,
   input  logic                  resetn,
   output logic [addrWidth-1:0]  imem_addr,
   input  logic [instrWidth-1:0] imem_instr,
   input  logic                  redirect_valid,
   input  logic [addrWidth-1:0]  redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [addrWidth-1:0]  out_pc,
   output logic [instrWidth-1:0] out_instr,
   output logic                  out_fault
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t               state;
   logic [addrWidth-1:0] pc_q;
   logic                 vld_q;
   logic                 fire;
   logic                 misaligned;

   assign misaligned = (redirect_pc[1:0] != 2'b00);

   // Output and next-address selection. While decode stalls, the current
   // address is re-read so the presented word stays stable.
   always_comb begin
      out_valid = 1'b0;
      out_fault = 1'b0;
      out_pc    = pc_q;
      out_instr = imem_instr;
      imem_addr = pc_q;
      fire      = 1'b0;
      case (state)
         RUN: begin
            out_valid = vld_q & ~redirect_valid;
            fire      = out_valid & out_ready;
            if (redirect_valid)
               imem_addr = redirect_pc;
            else if (fire)
               imem_addr = pc_q + addrWidth'(4);
            else
               imem_addr = pc_q;
         end
         FAULT: begin
            out_fault = 1'b1;
         end
         default: begin
            imem_addr = pc_q;
         end
      endcase
   end

   // State, PC and valid tracking. pc_q follows whatever address the memory
   // captured at this edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= BOOT;
         pc_q  <= resetVector;
         vld_q <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state <= RUN;
               vld_q <= 1'b1;
            end
            RUN: begin
               pc_q  <= imem_addr;
               vld_q <= 1'b1;
               if (redirect_valid && misaligned) begin
                  state <= FAULT;
                  vld_q <= 1'b0;
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state <= BOOT;
               vld_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a registered memory model feeds the DUT. Expected
// PCs are queued as each stimulus segment is set up. A negedge monitor pops
// one entry per completed handshake and compares it with the presented PC and
// word. Directed checks cover reset, backpressure, redirect, fault and wrap.
module tb_instr_fetch;

   localparam logic [31:0] RV = 32'h8000_0000;

   logic        clock;
   logic        resetn;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   instr_fetch #(
      .addrWidth(32),
      .instrWidth(32),
      .resetVector(RV)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .imem_addr(imem_addr),
      .imem_instr(imem_instr),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pc(out_pc),
      .out_instr(out_instr),
      .out_fault(out_fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h8000_0000: mem_word = 32'h0000_0013;
         32'h8000_0004: mem_word = 32'h0000_0093;
         32'h8000_0008: mem_word = 32'h0000_0113;
         32'h8000_000C: mem_word = 32'h0000_0193;
         default:       mem_word = {a[31:2], 2'b00} ^ 32'h5A5A_0000;
      endcase
   endfunction

   // Registered memory: captures the address at every posedge.
   always @(posedge clock) imem_instr <= mem_word(imem_addr);

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard monitor: one pop per completed handshake.
   always @(negedge clock) begin
      if (resetn && out_valid && out_ready) begin
         check("sb_have_exp", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("sb_pc", 64'(out_pc), 64'(e));
            check("sb_instr", 64'(out_instr), 64'(mem_word(e)));
         end
      end
   end

   initial begin
      resetn         = 1'b0;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      cyc();
      #2;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_fault", 64'(out_fault), 64'd0);
      check("rst_pc", 64'(out_pc), 64'(RV));
      check("rst_addr", 64'(imem_addr), 64'(RV));

      // Streaming, backpressure, redirect and wrap segment.
      exp_q.push_back(32'h8000_0000);
      exp_q.push_back(32'h8000_0004);
      exp_q.push_back(32'h8000_0008);
      exp_q.push_back(32'h8000_000C);
      exp_q.push_back(32'h8000_0100);
      exp_q.push_back(32'h8000_0104);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);

      cyc(); resetn = 1'b1; #2;
      check("boot_valid", 64'(out_valid), 64'd0);
      cyc(); #2;
      check("first_valid", 64'(out_valid), 64'd1);
      check("first_pc", 64'(out_pc), 64'(RV));
      cyc();
      for (int i = 0; i < 3; i++) begin
         cyc(); out_ready = 1'b0; #2;
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_pc", 64'(out_pc), 64'h8000_0008);
         check("bp_instr", 64'(out_instr), 64'h113);
         check("bp_addr", 64'(imem_addr), 64'h8000_0008);
      end
      cyc(); out_ready = 1'b1; #2;
      check("bp_release_pc", 64'(out_pc), 64'h8000_0008);
      cyc(); #2;
      check("after_bp_pc", 64'(out_pc), 64'h8000_000C);

      cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; #2;
      check("redir_squash", 64'(out_valid), 64'd0);
      check("redir_addr", 64'(imem_addr), 64'h8000_0100);
      cyc(); redirect_valid = 1'b0; #2;
      check("redir_valid", 64'(out_valid), 64'd1);
      check("redir_pc", 64'(out_pc), 64'h8000_0100);
      cyc();

      cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #2;
      check("wrap_squash", 64'(out_valid), 64'd0);
      cyc(); redirect_valid = 1'b0; #2;
      check("wrap_pc_top", 64'(out_pc), 64'hFFFF_FFFC);
      check("wrap_addr", 64'(imem_addr), 64'h0);
      cyc(); #2;
      check("wrap_pc_zero", 64'(out_pc), 64'h0);
      check("wrap_valid", 64'(out_valid), 64'd1);
      check("wrap_fault", 64'(out_fault), 64'd0);

      // Misaligned redirect and sticky fault.
      cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; #2;
      check("mis_valid", 64'(out_valid), 64'd0);
      check("mis_addr", 64'(imem_addr), 64'h8000_0102);
      check("sb_drained_1", 64'(exp_q.size()), 64'd0);
      cyc(); redirect_pc = 32'h8000_0200; #2;
      check("fault_flag", 64'(out_fault), 64'd1);
      check("fault_pc", 64'(out_pc), 64'h8000_0102);
      check("fault_valid", 64'(out_valid), 64'd0);
      check("fault_addr", 64'(imem_addr), 64'h8000_0102);
      cyc(); redirect_valid = 1'b0; #2;
      check("fault_sticky", 64'(out_fault), 64'd1);
      check("fault_pc_hold", 64'(out_pc), 64'h8000_0102);

      cyc(); resetn = 1'b0; #1;
      check("clr_fault", 64'(out_fault), 64'd0);
      check("clr_valid", 64'(out_valid), 64'd0);
      check("clr_pc", 64'(out_pc), 64'(RV));
      check("clr_addr", 64'(imem_addr), 64'(RV));

      // Restart, then asynchronous reset in the middle of a cycle.
      cyc(); resetn = 1'b1;
      exp_q.push_back(32'h8000_0000);
      exp_q.push_back(32'h8000_0004);
      exp_q.push_back(32'h8000_0008);
      #2;
      check("reboot_valid", 64'(out_valid), 64'd0);
      cyc(); cyc(); cyc();
      cyc(); #1;
      check("pre_async_pc", 64'(out_pc), 64'h8000_000C);
      #1 resetn = 1'b0;
      #1;
      check("async_valid", 64'(out_valid), 64'd0);
      check("async_addr", 64'(imem_addr), 64'(RV));
      check("async_pc", 64'(out_pc), 64'(RV));
      check("sb_drained_2", 64'(exp_q.size()), 64'd0);

      cyc(); resetn = 1'b1;
      exp_q.push_back(32'h8000_0000);
      exp_q.push_back(32'h8000_0004);
      cyc(); #2;
      check("restart_pc", 64'(out_pc), 64'(RV));
      cyc();
      cyc(); out_ready = 1'b0; #2;
      check("restart_third_pc", 64'(out_pc), 64'h8000_0008);
      cyc();
      check("sb_drained_3", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
